// File: rtl/ffe_weight_loader.sv
// Configuration-side writer for the FFE weight/shift interface: commands fill a shadow
// bank, and a commit copies the whole bank into the active (FFE-facing) bank on frame_sync.
module ffe_weight_loader #(
    parameter int weightBitwidth   = 8,
    parameter int shiftBitwidth    = 5,
    parameter int ffeDepth         = 16,
    parameter int numChannels      = 16,
    parameter int tapAddrBitwidth  = $clog2(ffeDepth),
    parameter int chanAddrBitwidth = $clog2(numChannels)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [1:0]                         cmd_op,
    input  logic [tapAddrBitwidth-1:0]         cmd_tap,
    input  logic [chanAddrBitwidth-1:0]        cmd_chan,
    input  logic signed [weightBitwidth-1:0]   cmd_data,
    input  logic                               frame_sync,
    output logic signed [weightBitwidth-1:0]   new_weights [ffeDepth][numChannels],
    output logic [shiftBitwidth-1:0]           new_shift_index [numChannels],
    input  logic [tapAddrBitwidth-1:0]         rd_tap,
    input  logic [chanAddrBitwidth-1:0]        rd_chan,
    output logic signed [weightBitwidth-1:0]   rd_weight,
    output logic [shiftBitwidth-1:0]           rd_shift,
    output logic                               update_pending,
    output logic                               commit_done,
    output logic                               addr_err
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
    localparam logic [1:0] ST_DONE      = 2'd2;

    localparam logic [1:0] OP_WR_WEIGHT = 2'd0;
    localparam logic [1:0] OP_WR_SHIFT  = 2'd1;
    localparam logic [1:0] OP_BCAST     = 2'd2;
    localparam logic [1:0] OP_COMMIT    = 2'd3;

    logic [1:0]                       state_r;
    logic [1:0]                       state_next_s;
    logic signed [weightBitwidth-1:0] shadow_weight_r [ffeDepth][numChannels];
    logic [shiftBitwidth-1:0]         shadow_shift_r [numChannels];

    logic        accept_s;
    logic        wr_en_s;
    logic        wr_ok_s;
    logic        commit_edge_s;
    logic        tap_ok_s;
    logic        chan_ok_s;
    logic        rd_tap_ok_s;
    logic        rd_chan_ok_s;
    logic [31:0] cmd_tap_ext_s;
    logic [31:0] cmd_chan_ext_s;
    logic [31:0] rd_tap_ext_s;
    logic [31:0] rd_chan_ext_s;

    // Command decode and address range checks (sizes need not be powers of two)
    always_comb begin
        cmd_tap_ext_s  = 32'(cmd_tap);
        cmd_chan_ext_s = 32'(cmd_chan);
        rd_tap_ext_s   = 32'(rd_tap);
        rd_chan_ext_s  = 32'(rd_chan);
        tap_ok_s       = (cmd_tap_ext_s < 32'(ffeDepth));
        chan_ok_s      = (cmd_chan_ext_s < 32'(numChannels));
        rd_tap_ok_s    = (rd_tap_ext_s < 32'(ffeDepth));
        rd_chan_ok_s   = (rd_chan_ext_s < 32'(numChannels));
        accept_s       = cmd_valid && cmd_ready;
        wr_en_s        = accept_s && (cmd_op != OP_COMMIT);
        commit_edge_s  = (state_r == ST_WAIT_SYNC) && frame_sync;
        case (cmd_op)
            OP_WR_WEIGHT: wr_ok_s = tap_ok_s && chan_ok_s;
            OP_WR_SHIFT:  wr_ok_s = chan_ok_s;
            OP_BCAST:     wr_ok_s = tap_ok_s;
            default:      wr_ok_s = 1'b0;
        endcase
    end

    // Next-state logic for the commit sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cmd_op == OP_COMMIT)) begin
                    state_next_s = ST_WAIT_SYNC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_SYNC: begin
                if (frame_sync) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT_SYNC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Shadow bank: accepted in-range writes land here, never on the FFE directly
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < ffeDepth; t++) begin
                for (int c = 0; c < numChannels; c++) begin
                    shadow_weight_r[t][c] <= '0;
                end
            end
            for (int c = 0; c < numChannels; c++) begin
                shadow_shift_r[c] <= '0;
            end
        end else if (wr_en_s && wr_ok_s) begin
            case (cmd_op)
                OP_WR_WEIGHT: shadow_weight_r[cmd_tap][cmd_chan] <= cmd_data;
                OP_WR_SHIFT:  shadow_shift_r[cmd_chan] <= cmd_data[shiftBitwidth-1:0];
                OP_BCAST: begin
                    for (int c = 0; c < numChannels; c++) begin
                        shadow_weight_r[cmd_tap][c] <= cmd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Active bank: whole-bank copy in a single edge keeps the FFE coherent
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < ffeDepth; t++) begin
                for (int c = 0; c < numChannels; c++) begin
                    new_weights[t][c] <= '0;
                end
            end
            for (int c = 0; c < numChannels; c++) begin
                new_shift_index[c] <= '0;
            end
        end else if (commit_edge_s) begin
            new_weights     <= shadow_weight_r;
            new_shift_index <= shadow_shift_r;
        end
    end

    // Registered readback of the active bank
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_weight <= '0;
            rd_shift  <= '0;
        end else begin
            if (rd_tap_ok_s && rd_chan_ok_s) begin
                rd_weight <= new_weights[rd_tap][rd_chan];
            end else begin
                rd_weight <= '0;
            end
            if (rd_chan_ok_s) begin
                rd_shift <= new_shift_index[rd_chan];
            end else begin
                rd_shift <= '0;
            end
        end
    end

    // Sequencer state plus registered handshake and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cmd_ready      <= 1'b1;
            commit_done    <= 1'b0;
            update_pending <= 1'b0;
            addr_err       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cmd_ready   <= (state_next_s == ST_IDLE);
            commit_done <= (state_next_s == ST_DONE);
            if (commit_edge_s) begin
                update_pending <= 1'b0;
                addr_err       <= 1'b0;
            end else if (wr_en_s) begin
                if (wr_ok_s) begin
                    update_pending <= 1'b1;
                end else begin
                    addr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/ffe_weight_loader.md
Name: ffe_weight_loader

Overview:
- Configuration-side writer for the flat FFE weight/shift interface.
- Accepts single-word write commands over a valid/ready handshake into a shadow bank.
- On a commit command, waits for the next frame_sync pulse, then atomically copies the shadow bank into the active bank.
- The active bank drives the FFE's new_weights/new_shift_index inputs directly, so the datapath never sees a half-updated weight set.

Parameters:
weightBitwidth, 8, signed weight word width
shiftBitwidth, 5, shift index width
ffeDepth, 16, taps per channel
numChannels, 16, parallel channels
tapAddrBitwidth, $clog2(ffeDepth), tap address width
chanAddrBitwidth, $clog2(numChannels), channel address width

Ports:
clk  input  1  single clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  loader can accept command
cmd_op  input  2  0=write weight, 1=write shift, 2=broadcast weight (tap to all channels), 3=commit
cmd_tap  input  tapAddrBitwidth  tap index (ops 0,2)
cmd_chan  input  chanAddrBitwidth  channel index (ops 0,1)
cmd_data  input  weightBitwidth  signed weight (ops 0,2); low shiftBitwidth bits used for op 1
frame_sync  input  1  one-cycle strobe marking a safe update boundary
new_weights  output  signed weightBitwidth, [ffeDepth][numChannels]  active weights to FFE
new_shift_index  output  shiftBitwidth, [numChannels]  active shift to FFE
rd_tap  input  tapAddrBitwidth  readback tap
rd_chan  input  chanAddrBitwidth  readback channel
rd_weight  output  signed weightBitwidth  registered active weight at (rd_tap, rd_chan)
rd_shift  output  shiftBitwidth  registered active shift at rd_chan
update_pending  output  1  shadow differs from active by at least one accepted write since last commit
commit_done  output  1  one-cycle pulse after active bank update
addr_err  output  1  sticky: out-of-range address seen

Behaviour:
- Reset (rst high at a clk edge): shadow and active banks = 0; rd_weight = rd_shift = 0; update_pending = commit_done = addr_err = 0; state = IDLE; cmd_ready = 1 from the first cycle after reset. Reset has priority over all other activity, including an in-progress commit, which is abandoned without updating the active bank.
- FSM states:
  - IDLE: cmd_ready = 1. Handshake completes when cmd_valid & cmd_ready.
    - ops 0/1/2: update the shadow bank at that edge, set update_pending, stay in IDLE.
    - op 3: go to WAIT_SYNC.
  - WAIT_SYNC: cmd_ready = 0. The first frame_sync strictly after the commit-accept edge causes the copy at that edge; go to DONE. A frame_sync in the same cycle as commit acceptance does not count.
  - DONE: commit_done = 1 for exactly this cycle; cmd_ready = 0; return to IDLE.
- Commit copy: the active bank takes the full shadow bank in one edge. update_pending clears; addr_err also clears on this edge.
- Commit with update_pending = 0 is legal: the active bank is rewritten with identical values, and commit_done still pulses.
- Write-op details:
  - op 2 writes shadow[tap][c] for every channel c.
  - op 1 writes shadow_shift[chan] = cmd_data[shiftBitwidth-1:0].
- Address range: tap >= ffeDepth or chan >= numChannels (non-power-of-two sizes) means the write is dropped and addr_err is set. The command is still consumed and update_pending is unchanged. Op 2 checks tap only.
- Repeated writes to the same location: the last write wins.
- Output timing:
  - new_weights/new_shift_index are register outputs of the active bank. They change only on a commit edge or reset.
  - Readback: rd_weight/rd_shift update one cycle after rd_tap/rd_chan and reflect the active bank as of that edge. An out-of-range read returns 0.
- Command fields are ignored when no handshake occurs. cmd_valid may stay high while cmd_ready = 0; the command is held, not lost.

Test Plan:
- Reset, then write op0 tap=3 chan=5 data=-7 -> new_weights[3][5] stays 0 and update_pending=1. Commit plus frame_sync 4 cycles later -> new_weights[3][5]=-7 on the sync edge, commit_done pulses 1 cycle later, update_pending=0.
- Broadcast op2 tap=0 data=0x40, commit -> all 16 channels show new_weights[0][*]=64; other taps remain 0.
- frame_sync high on the same cycle the commit is accepted -> no update. The next frame_sync applies it; cmd_ready stays 0 throughout WAIT_SYNC, and a held write command is accepted only after commit_done.
- Write op1 chan=2 data=0x3F -> shadow shift=31 (low 5 bits); after commit new_shift_index[2]=31 and rd_shift=31 one cycle after rd_chan=2.
- With ffeDepth=12, write tap=13 -> addr_err=1, no bank change, update_pending unchanged; the following commit clears addr_err.
- Assert rst while in WAIT_SYNC after a shadow write of 9 -> all outputs 0 and state IDLE. A later commit with no new writes leaves that weight at 0.
